// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and state encoding for the FIR tap sequencer
package fir_pkg;
    localparam int CW = 25;
    localparam int DW = 18;
    localparam int AW_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/fir_dpram.sv
// rtl/fir_dpram.sv - simple dual-port RAM, synchronous write, asynchronous read
module fir_dpram #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read returns the pre-write contents during a same-address write.
    assign rdata = mem[raddr];
endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - circular sample delay line feeding framed coefficient/sample bursts to the MAC
module fir_tap_sequencer #(
    parameter int AW = fir_pkg::AW_DEFAULT,
    parameter int CW = fir_pkg::CW,
    parameter int DW = fir_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sin,
    input  logic          sin_stb,
    input  logic          cwe,
    input  logic [AW-1:0] caddr,
    input  logic [CW-1:0] cdata,
    output logic [CW-1:0] cin,
    output logic [DW-1:0] din,
    output logic          first,
    output logic          last,
    output logic          busy,
    output logic          ovr
);
    import fir_pkg::*;

    localparam int TAPS = 2**AW;
    localparam logic [AW:0] FILL_MAX = (AW+1)'(TAPS);

    state_t        state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] tap;
    logic [AW:0]   fill;

    logic          tap_last;
    logic          accept;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          hist_valid;
    logic [CW-1:0] coef;
    logic [DW-1:0] samp;

    assign tap_last   = (tap == '1);
    assign accept     = sin_stb && ((state == IDLE) || tap_last);
    assign wr_ptr     = wptr + 1'b1;
    assign rd_ptr     = wptr - tap;
    assign hist_valid = ({1'b0, tap} < fill);

    fir_dpram #(.AW(AW), .W(CW)) u_coef (
        .clk   (clk),
        .we    (cwe),
        .waddr (caddr),
        .wdata (cdata),
        .raddr (tap),
        .rdata (coef)
    );

    // On a back-to-back accept the write lands on the slot the final tap reads;
    // the asynchronous read still presents the old sample to the output register.
    fir_dpram #(.AW(AW), .W(DW)) u_samp (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (sin),
        .raddr (rd_ptr),
        .rdata (samp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wptr  <= '0;
            tap   <= '0;
            fill  <= '0;
            cin   <= '0;
            din   <= '0;
            first <= 1'b0;
            last  <= 1'b0;
            busy  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            ovr <= 1'b0;
            if (accept) begin
                wptr <= wr_ptr;
                fill <= (fill == FILL_MAX) ? fill : fill + 1'b1;
            end
            case (state)
                IDLE: begin
                    cin   <= '0;
                    din   <= '0;
                    first <= 1'b0;
                    last  <= 1'b0;
                    busy  <= 1'b0;
                    tap   <= '0;
                    if (sin_stb) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    cin   <= coef;
                    din   <= hist_valid ? samp : '0;
                    first <= (tap == '0);
                    last  <= tap_last;
                    busy  <= 1'b1;
                    tap   <= tap + 1'b1;
                    if (tap_last) begin
                        if (!sin_stb) begin
                            state <= IDLE;
                        end
                    end else if (sin_stb) begin
                        ovr <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - self-checking bench for fir_tap_sequencer
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    localparam int AW   = 4;
    localparam int TAPS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sin;
    logic          sin_stb;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [CW-1:0] cdata;
    logic [CW-1:0] cin;
    logic [DW-1:0] din;
    logic          first, last, busy, ovr;

    int checks = 0;
    int errors = 0;

    fir_tap_sequencer #(.AW(AW), .CW(CW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .sin     (sin),
        .sin_stb (sin_stb),
        .cwe     (cwe),
        .caddr   (caddr),
        .cdata   (cdata),
        .cin     (cin),
        .din     (din),
        .first   (first),
        .last    (last),
        .busy    (busy),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;

    // Reference model: history of accepted samples (newest first) and a queue
    // of pending output beats, each remembering its tap index and sample.
    typedef struct {
        int k;
        int d;
    } ent_t;

    int   h_m [TAPS];
    int   hist [$];
    ent_t pend [$];
    int   e_cin, e_din;
    bit   e_first, e_last, e_busy, e_ovr;

    task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(bit stb, int s, bit we, int a, int d);
        bit acc;
        ent_t e;
        logic signed [DW-1:0] sv;
        logic signed [CW-1:0] dv;
        acc = stb && (pend.size() <= 1);
        if (pend.size() > 0) begin
            e       = pend.pop_front();
            e_cin   = h_m[e.k];
            e_din   = e.d;
            e_first = (e.k == 0);
            e_last  = (e.k == TAPS-1);
            e_busy  = 1'b1;
        end else begin
            e_cin = 0; e_din = 0; e_first = 0; e_last = 0; e_busy = 0;
        end
        e_ovr = stb && !acc;
        if (acc) begin
            sv = s[DW-1:0];
            hist.push_front(int'(sv));
            if (hist.size() > TAPS) void'(hist.pop_back());
            for (int k = 0; k < TAPS; k++) begin
                e.k = k;
                e.d = (k < hist.size()) ? hist[k] : 0;
                pend.push_back(e);
            end
        end
        if (we) begin
            dv = d[CW-1:0];
            h_m[a % TAPS] = int'(dv);
        end
    endtask

    task automatic cyc(bit stb, int s, bit we = 1'b0, int a = 0, int d = 0);
        sin_stb = stb;
        sin     = s[DW-1:0];
        cwe     = we;
        caddr   = a[AW-1:0];
        cdata   = d[CW-1:0];
        @(posedge clk);
        model_edge(stb, s, we, a, d);
        @(negedge clk);
        sin_stb = 1'b0;
        cwe     = 1'b0;
        chk("cin",   $signed(cin), e_cin);
        chk("din",   $signed(din), e_din);
        chk("first", first, e_first);
        chk("last",  last,  e_last);
        chk("busy",  busy,  e_busy);
        chk("ovr",   ovr,   e_ovr);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_cin"},   cin,   0);
        chk({tag, "_din"},   din,   0);
        chk({tag, "_first"}, first, 0);
        chk({tag, "_last"},  last,  0);
        chk({tag, "_busy"},  busy,  0);
        chk({tag, "_ovr"},   ovr,   0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 chk_zero("rst_async");
        pend.delete();
        hist.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit stb;
        int s;
        int cin;
        int din;
        bit first, last, busy, ovr;
    } vec_t;

    vec_t vt [20];
    int   exp_hist [4] = '{1000, 100, 10, 1};
    int   hist_in  [3] = '{10, 100, 1000};

    initial begin
        for (int i = 0; i < 20; i++) begin
            vt[i] = '{stb: (i == 0), s: (i == 0) ? 1 : 0,
                      cin: (i >= 1 && i <= 16) ? 262144 : 0,
                      din: (i == 1) ? 1 : 0,
                      first: (i == 1), last: (i == 16),
                      busy: (i >= 1 && i <= 16), ovr: 1'b0};
        end
        for (int k = 0; k < TAPS; k++) h_m[k] = 0;

        rst = 1'b1; sin = '0; sin_stb = 1'b0; cwe = 1'b0; caddr = '0; cdata = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        cyc(0, 0);

        // Impulse response with flat coefficients, from the vector table
        for (int k = 0; k < TAPS; k++) cyc(0, 0, 1, k, 262144);
        for (int i = 0; i < 20; i++) begin
            cyc(vt[i].stb, vt[i].s);
            chk("tbl_cin",   $signed(cin), vt[i].cin);
            chk("tbl_din",   $signed(din), vt[i].din);
            chk("tbl_first", first, vt[i].first);
            chk("tbl_last",  last,  vt[i].last);
            chk("tbl_busy",  busy,  vt[i].busy);
            chk("tbl_ovr",   ovr,   vt[i].ovr);
        end

        // History order with h[k]=k
        for (int k = 0; k < TAPS; k++) cyc(0, 0, 1, k, k);
        for (int j = 0; j < 3; j++) begin
            cyc(1, hist_in[j]);
            for (int k = 0; k < TAPS; k++) begin
                cyc(0, 0);
                if (j == 2) begin
                    chk("hist_cin", $signed(cin), k);
                    chk("hist_din", $signed(din), (k < 4) ? exp_hist[k] : 0);
                end
            end
            cyc(0, 0);
        end

        // Back-to-back: strobe while the final tap is launched
        cyc(1, 7);
        for (int k = 0; k < TAPS-1; k++) cyc(0, 0);
        cyc(1, 8);
        chk("b2b_last", last, 1);
        chk("b2b_ovr", ovr, 0);
        cyc(0, 0);
        chk("b2b_first", first, 1);
        chk("b2b_busy", busy, 1);
        chk("b2b_din0", $signed(din), 8);
        for (int k = 1; k < TAPS+2; k++) cyc(0, 0);

        // Overrun at tap 5
        cyc(1, 55);
        for (int k = 0; k < 5; k++) cyc(0, 0);
        cyc(1, 777);
        chk("ovr_pulse", ovr, 1);
        cyc(0, 0);
        chk("ovr_clear", ovr, 0);
        chk("ovr_busy", busy, 1);
        for (int k = 7; k < TAPS+2; k++) cyc(0, 0);
        cyc(1, 66);
        cyc(0, 0);
        cyc(0, 0);
        chk("ovr_dropped", $signed(din), 55);
        for (int k = 2; k < TAPS+2; k++) cyc(0, 0);

        // Reset mid-burst, then history must read as zero
        cyc(1, 9);
        for (int k = 0; k < 5; k++) cyc(0, 0);
        do_reset();
        cyc(0, 0);
        chk_zero("post_rst");
        cyc(1, 5);
        for (int k = 0; k < TAPS+2; k++) begin
            cyc(0, 0);
            if (k >= 1 && k < TAPS) chk("rst_hist_din", $signed(din), 0);
        end

        // Wrap and full fill: -1..-20 back-to-back
        for (int i = 1; i <= 20; i++) begin
            cyc(1, -i);
            if (i < 20) for (int k = 0; k < TAPS-1; k++) cyc(0, 0);
        end
        for (int k = 0; k < TAPS; k++) begin
            cyc(0, 0);
            chk("wrap_din", $signed(din), -20 + k);
        end
        cyc(0, 0);
        chk("wrap_idle", busy, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 5) == 0), int'($urandom),
                ($urandom_range(0, 15) == 0), int'($urandom_range(0, TAPS-1)), int'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Producer side of the mac18x25x20 stream interface.
- Accepts strobed 18-bit input samples and stores them in a circular delay line.
- For every accepted sample, emits one framed burst of 2^AW (coefficient, sample) pairs on cin/din, with first/last strobes, ready to wire directly to mac18x25x20.
- Sits between the decimator/sample source and the MAC in the FIR filter chain.

Parameters:
- AW, 4: log2 of tap count. TAPS = 2^AW (localparam); pointer wrap is natural modulo 2^AW.
- CW, 25: coefficient width; must match the MAC cin width.
- DW, 18: sample width; must match the MAC din width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- sin  in  DW  input sample, two's complement.
- sin_stb  in  1  sample valid strobe, one clk wide.
- cwe  in  1  coefficient write enable.
- caddr  in  AW  coefficient index k (h[k]).
- cdata  in  CW  coefficient value, two's complement.
- cin  out  CW  coefficient to MAC.
- din  out  DW  sample to MAC.
- first  out  1  marks tap 0 of a burst.
- last  out  1  marks tap TAPS-1 of a burst.
- busy  out  1  burst in progress.
- ovr  out  1  one-cycle pulse: sample dropped.

Behaviour:
- Reset (async, rst=1): state=IDLE; wptr=0, tap=0, fill=0. Outputs cin=0, din=0, first=0, last=0, busy=0, ovr=0. Coefficient RAM and sample RAM are not cleared.
- States: IDLE, RUN.
- IDLE + sin_stb:
  - Write sin to sbuf[wptr+1] (the new newest entry); wptr <= wptr+1.
  - fill <= min(fill+1, TAPS); tap <= 0; state <= RUN.
- RUN, per clk, registered outputs for tap k:
  - cin = h[k].
  - din = x[n-k] = sbuf[wptr-k], or 0 when k >= fill (unwritten history reads as zero).
  - first = (k==0); last = (k==TAPS-1); busy = 1.
- Latency: sin_stb sampled at edge E0 → first=1 after edge E1. Burst is exactly TAPS consecutive cycles, with no gaps.
- After the last tap:
  - Without a new sample: state <= IDLE; outputs return to cin=0, din=0, first=0, last=0, busy=0.
- Acceptance window: sin_stb is accepted in IDLE, or in RUN on the cycle whose outgoing edge registers tap TAPS-1 (i.e. the final tap is being launched).
  - In the second case the next burst starts back-to-back: last=1 in one cycle, first=1 in the next.
  - The write overwrites the oldest slot. Read-before-write is required: the register captures the old value for the final tap.
- sin_stb at any other RUN cycle: sample discarded; ovr=1 for one cycle; the burst continues unchanged; wptr and fill are unchanged.
- Coefficient writes: accepted in any state; h[caddr] <= cdata at the edge. A read of the same address in the same cycle returns the old value. Software loads coefficients while idle.
- Reset mid-burst: the burst is aborted immediately and last is never emitted. The MAC shares rst, so no partial result appears.
- fill saturates at TAPS and never wraps.

Decomposition:
- Shared package fir_pkg: constants CW=25, DW=18 (shared with the MAC); default AW.
- One sub-module: fir_dpram, a generic simple dual-port RAM.
  - Synchronous write; asynchronous read, so it maps to distributed RAM.
  - Instantiated twice: coefficient store and sample store.
- FSM, pointers, fill counter and output registers stay in the top level.

Test Plan:
- Reset: rst pulse mid-simulation → all outputs 0, busy=0; a subsequent sample sees din=0 for taps 1..15.
- Single impulse: h[k]=262144 for all k; sin=1 once → first after 1 clk; 16 cycles cin=262144, din=1 then 0×15; last on cycle 16; busy low after.
- History order: samples 1,10,100,1000 (each after the previous burst) → fourth burst din sequence 1000,100,10,1,0…0; h[k]=k shows cin=0..15.
- Back-to-back: sin_stb coincident with launching the last tap → next cycle first=1; no idle gap; ovr=0.
- Overrun: sin_stb at tap 5 → ovr pulse 1 cycle; burst continues with unchanged din; next accepted sample's burst shows the dropped value absent.
- Wrap + full fill: 20 samples −1..−20 → the 20th burst din = −20…−5 (16 values); pointer wrap is seamless.
